// File: rtl/mlp_activation_packer_if.sv
// Bundle of signals between the age-read stage, the packer and the MLP engine.
// The master side drives the upstream beats and act_ready; the slave side is the packer.
interface mlp_activation_packer_if #(
  parameter int TIMESTAMP_BITS = 16,
  parameter int POLARITY_BITS  = 2,
  parameter int NUM_PAIRS      = 25,
  parameter int ACT_BITS       = 8
);
  logic [TIMESTAMP_BITS-1:0]       MLPout1;
  logic [POLARITY_BITS-1:0]        MLPout2;
  logic [TIMESTAMP_BITS-1:0]       MLPout3;
  logic [POLARITY_BITS-1:0]        MLPout4;
  logic                            MLPvld;
  logic                            done;
  logic                            busy;
  logic [2*NUM_PAIRS*ACT_BITS-1:0] act_vec;
  logic                            act_valid;
  logic                            act_ready;
  logic                            err_short;
  logic                            err_ovf;

  modport master (
    output MLPout1, MLPout2, MLPout3, MLPout4, MLPvld, done, act_ready,
    input  busy, act_vec, act_valid, err_short, err_ovf
  );

  modport slave (
    input  MLPout1, MLPout2, MLPout3, MLPout4, MLPvld, done, act_ready,
    output busy, act_vec, act_valid, err_short, err_ovf
  );
endinterface

// File: rtl/mlp_activation_packer.sv
// Quantises age/polarity pairs into signed recency activations and packs one
// event frame per bank of a two-bank ping-pong buffer; full banks are handed
// to the MLP engine over valid/ready.
//
// bank state | meaning
// -----------+-----------------------------------------------
// S_EMPTY    | free, may start collecting a frame
// S_FILL     | at least one pair written, frame in progress
// S_FULL     | frame complete, waiting for act_ready
module mlp_activation_packer #(
  parameter int TIMESTAMP_BITS = 16,
  parameter int POLARITY_BITS  = 2,
  parameter int NUM_PAIRS      = 25,
  parameter int ACT_BITS       = 8,
  parameter int AGE_SHIFT      = 6
) (
  input logic clk,
  input logic rst,
  mlp_activation_packer_if.slave bus
);

  localparam int NUM_ELEMS = 2 * NUM_PAIRS;
  localparam int KW        = $clog2(NUM_PAIRS + 1);
  localparam int EW        = $clog2(NUM_ELEMS);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [ACT_BITS-1:0] MAG_MAX = {1'b0, {(ACT_BITS-1){1'b1}}};
  localparam logic [KW-1:0]       K_MAX   = KW'(NUM_PAIRS);

  logic [1:0]          r_state [2];
  logic                r_wptr;
  logic                r_rptr;
  logic [KW-1:0]       r_k;
  logic                r_busy;
  logic                r_act_valid;
  logic                r_err_short;
  logic                r_err_ovf;
  logic [ACT_BITS-1:0] r_mem [2][NUM_ELEMS];

  logic [1:0]          w_st_nx [2];
  logic                w_wptr_nx;
  logic                w_rptr_nx;
  logic [KW-1:0]       w_k_inc;
  logic [KW-1:0]       w_k_nx;
  logic [1:0]          w_wst;
  logic                w_beat;
  logic                w_drop;
  logic                w_close;
  logic                w_full_close;
  logic                w_short;
  logic                w_hs;
  logic [EW-1:0]       w_e0;
  logic [EW-1:0]       w_e1;
  logic [ACT_BITS-1:0] w_act0;
  logic [ACT_BITS-1:0] w_act1;
  logic [NUM_ELEMS*ACT_BITS-1:0] w_vec;

  // Saturation compares the full shifted age so large ages never wrap back to high recency.
  function automatic logic [ACT_BITS-1:0] quant(
    input logic [TIMESTAMP_BITS-1:0] age,
    input logic [POLARITY_BITS-1:0]  pol
  );
    logic [TIMESTAMP_BITS-1:0] sh;
    logic [ACT_BITS-1:0]       mag;
    logic [ACT_BITS-1:0]       rec;
    sh = age >> AGE_SHIFT;
    if (sh > TIMESTAMP_BITS'(MAG_MAX)) mag = MAG_MAX;
    else                               mag = sh[ACT_BITS-1:0];
    rec = MAG_MAX - mag;
    if (pol == POLARITY_BITS'(1))      quant = rec;
    else if (pol == POLARITY_BITS'(2)) quant = -rec;
    else                               quant = '0;
  endfunction

  // Quantise both elements of the incoming pair and locate their slots.
  always_comb begin
    w_act0 = quant(bus.MLPout1, bus.MLPout2);
    w_act1 = quant(bus.MLPout3, bus.MLPout4);
    w_e0   = EW'({r_k, 1'b0});
    w_e1   = w_e0 | EW'(1);
  end

  // Bank bookkeeping: the beat is counted before done is judged, so a closing
  // done can share its cycle with the last beat. Close and handshake always hit
  // different banks (close needs a non-full bank, handshake a full one).
  always_comb begin
    w_wst        = r_state[r_wptr];
    w_beat       = bus.MLPvld && (w_wst != S_FULL) && (r_k < K_MAX);
    w_drop       = bus.MLPvld && (w_wst == S_FULL);
    w_k_inc      = r_k + KW'(w_beat);
    w_close      = bus.done && (w_wst != S_FULL);
    w_full_close = w_close && (w_k_inc == K_MAX);
    w_short      = w_close && !w_full_close;
    w_hs         = r_act_valid && bus.act_ready;

    w_st_nx[0] = r_state[0];
    w_st_nx[1] = r_state[1];
    w_wptr_nx  = r_wptr;
    w_rptr_nx  = r_rptr;
    w_k_nx     = w_k_inc;

    if (w_beat && (w_wst == S_EMPTY)) w_st_nx[r_wptr] = S_FILL;
    if (w_full_close) begin
      w_st_nx[r_wptr] = S_FULL;
      w_wptr_nx       = ~r_wptr;
      w_k_nx          = '0;
    end else if (w_short) begin
      w_st_nx[r_wptr] = S_EMPTY;
      w_k_nx          = '0;
    end
    if (w_hs) begin
      w_st_nx[r_rptr] = S_EMPTY;
      w_rptr_nx       = ~r_rptr;
    end
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state[0]  <= S_EMPTY;
      r_state[1]  <= S_EMPTY;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_act_valid <= 1'b0;
      r_err_short <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_state[0]  <= w_st_nx[0];
      r_state[1]  <= w_st_nx[1];
      r_wptr      <= w_wptr_nx;
      r_rptr      <= w_rptr_nx;
      r_k         <= w_k_nx;
      r_busy      <= (w_st_nx[w_wptr_nx] == S_FULL);
      r_act_valid <= (w_st_nx[w_rptr_nx] == S_FULL);
      r_err_short <= w_short;
      r_err_ovf   <= r_err_ovf | w_drop;
    end
  end

  // Frame storage; stale contents are harmless because act_vec is gated by act_valid.
  always_ff @(posedge clk) begin
    if (!rst && w_beat) begin
      r_mem[r_wptr][w_e0] <= w_act0;
      r_mem[r_wptr][w_e1] <= w_act1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_vec
      assign w_vec[gi*ACT_BITS +: ACT_BITS] = r_act_valid ? r_mem[r_rptr][gi] : '0;
    end
  endgenerate

  assign bus.act_vec   = w_vec;
  assign bus.act_valid = r_act_valid;
  assign bus.busy      = r_busy;
  assign bus.err_short = r_err_short;
  assign bus.err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_mlp_activation_packer.sv
// Directed bench for mlp_activation_packer: quantiser table plus multi-cycle
// sequences for back-pressure, short frames, same-cycle events and reset.
module tb_mlp_activation_packer;
  localparam int VEC_W = 400;

  typedef struct {
    logic [15:0] a0;
    logic [1:0]  p0;
    logic [15:0] a1;
    logic [1:0]  p1;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  vec_t tab [6];

  mlp_activation_packer_if #(.TIMESTAMP_BITS(16), .POLARITY_BITS(2), .NUM_PAIRS(25), .ACT_BITS(8)) bus ();

  mlp_activation_packer #(
    .TIMESTAMP_BITS(16), .POLARITY_BITS(2), .NUM_PAIRS(25), .ACT_BITS(8), .AGE_SHIFT(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Pairs 0..23 carry (e0,e1); pair 24 carries (l0,l1).
  function automatic logic [VEC_W-1:0] mkvec(input logic [7:0] e0, input logic [7:0] e1,
                                             input logic [7:0] l0, input logic [7:0] l1);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int i = 24; i >= 0; i--) begin
      if (i == 24) v = {v[VEC_W-17:0], l1, l0};
      else         v = {v[VEC_W-17:0], e1, e0};
    end
    return v;
  endfunction

  task automatic drive(input logic [15:0] a0, input logic [1:0] p0, input logic [15:0] a1,
                       input logic [1:0] p1, input logic v, input logic d);
    bus.MLPout1 = a0;
    bus.MLPout2 = p0;
    bus.MLPout3 = a1;
    bus.MLPout4 = p1;
    bus.MLPvld  = v;
    bus.done    = d;
    @(posedge clk);
    #1;
    bus.MLPvld  = 1'b0;
    bus.done    = 1'b0;
  endtask

  task automatic beats(input logic [15:0] a0, input logic [1:0] p0, input logic [15:0] a1,
                       input logic [1:0] p1, input int n);
    for (int i = 0; i < n; i++) drive(a0, p0, a1, p1, 1'b1, 1'b0);
  endtask

  task automatic close_frame();
    drive(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'd0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic handshake();
    bus.act_ready = 1'b1;
    idle(1);
    bus.act_ready = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    tab[0] = '{a0: 16'd0,     p0: 2'b01, a1: 16'd640,   p1: 2'b10, e0: 8'h7F, e1: 8'h8B};
    tab[1] = '{a0: 16'h2000,  p0: 2'b01, a1: 16'd0,     p1: 2'b11, e0: 8'h00, e1: 8'h00};
    tab[2] = '{a0: 16'd63,    p0: 2'b01, a1: 16'd8064,  p1: 2'b10, e0: 8'h7F, e1: 8'hFF};
    tab[3] = '{a0: 16'd6400,  p0: 2'b01, a1: 16'h4040,  p1: 2'b10, e0: 8'h1B, e1: 8'h00};
    tab[4] = '{a0: 16'hFFFF,  p0: 2'b01, a1: 16'd64,    p1: 2'b10, e0: 8'h00, e1: 8'h82};
    tab[5] = '{a0: 16'd128,   p0: 2'b00, a1: 16'd8127,  p1: 2'b01, e0: 8'h00, e1: 8'h01};

    rst = 1'b1;
    bus.MLPout1 = '0; bus.MLPout2 = '0; bus.MLPout3 = '0; bus.MLPout4 = '0;
    bus.MLPvld = 1'b0; bus.done = 1'b0; bus.act_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_act_valid", VEC_W'(bus.act_valid), '0);
    chk("rst_busy",      VEC_W'(bus.busy),      '0);
    chk("rst_err_short", VEC_W'(bus.err_short), '0);
    chk("rst_err_ovf",   VEC_W'(bus.err_ovf),   '0);
    chk("rst_act_vec",   bus.act_vec,           '0);
    rst = 1'b0;
    idle(1);

    // Quantiser table: one full frame per record.
    for (int v = 0; v < 6; v++) begin
      beats(tab[v].a0, tab[v].p0, tab[v].a1, tab[v].p1, 25);
      chk($sformatf("tab%0d_pre_valid", v), VEC_W'(bus.act_valid), '0);
      close_frame();
      chk($sformatf("tab%0d_valid", v), VEC_W'(bus.act_valid), VEC_W'(1));
      chk($sformatf("tab%0d_vec", v), bus.act_vec, mkvec(tab[v].e0, tab[v].e1, tab[v].e0, tab[v].e1));
      handshake();
      chk($sformatf("tab%0d_post_valid", v), VEC_W'(bus.act_valid), '0);
    end

    // Back-pressure: two frames fill both banks.
    beats(16'd0, 2'b01, 16'd0, 2'b01, 25);
    close_frame();
    beats(16'd640, 2'b10, 16'd640, 2'b10, 25);
    chk("bp_busy_before", VEC_W'(bus.busy), '0);
    close_frame();
    chk("bp_busy",  VEC_W'(bus.busy), VEC_W'(1));
    chk("bp_valid", VEC_W'(bus.act_valid), VEC_W'(1));
    chk("bp_vec1",  bus.act_vec, mkvec(8'h7F, 8'h7F, 8'h7F, 8'h7F));
    drive(16'd0, 2'b01, 16'd0, 2'b01, 1'b1, 1'b0);
    chk("bp_ovf",      VEC_W'(bus.err_ovf), VEC_W'(1));
    chk("bp_vec1_hold", bus.act_vec, mkvec(8'h7F, 8'h7F, 8'h7F, 8'h7F));
    handshake();
    chk("bp_valid2",   VEC_W'(bus.act_valid), VEC_W'(1));
    chk("bp_vec2",     bus.act_vec, mkvec(8'h8B, 8'h8B, 8'h8B, 8'h8B));
    chk("bp_busy_clr", VEC_W'(bus.busy), '0);
    handshake();
    chk("bp_valid_clr", VEC_W'(bus.act_valid), '0);
    chk("bp_ovf_sticky", VEC_W'(bus.err_ovf), VEC_W'(1));

    // Short frame, then a clean full frame.
    beats(16'd0, 2'b01, 16'd0, 2'b01, 10);
    close_frame();
    chk("short_pulse", VEC_W'(bus.err_short), VEC_W'(1));
    chk("short_valid", VEC_W'(bus.act_valid), '0);
    idle(1);
    chk("short_pulse_end", VEC_W'(bus.err_short), '0);
    chk("short_valid2", VEC_W'(bus.act_valid), '0);
    beats(16'd640, 2'b01, 16'd0, 2'b10, 25);
    close_frame();
    chk("short_next_valid", VEC_W'(bus.act_valid), VEC_W'(1));
    chk("short_next_vec", bus.act_vec, mkvec(8'h75, 8'h81, 8'h75, 8'h81));
    handshake();

    // Last beat together with done.
    beats(16'd0, 2'b01, 16'd0, 2'b01, 24);
    drive(16'd640, 2'b10, 16'd6400, 2'b01, 1'b1, 1'b1);
    chk("same_valid", VEC_W'(bus.act_valid), VEC_W'(1));
    chk("same_vec", bus.act_vec, mkvec(8'h7F, 8'h7F, 8'h8B, 8'h1B));
    chk("same_short", VEC_W'(bus.err_short), '0);
    // Close on the other bank while the first is handed off.
    beats(16'd63, 2'b10, 16'd0, 2'b00, 24);
    bus.act_ready = 1'b1;
    drive(16'd63, 2'b10, 16'd0, 2'b00, 1'b1, 1'b1);
    bus.act_ready = 1'b0;
    chk("both_valid", VEC_W'(bus.act_valid), VEC_W'(1));
    chk("both_vec", bus.act_vec, mkvec(8'h81, 8'h00, 8'h81, 8'h00));
    chk("both_busy", VEC_W'(bus.busy), '0);
    handshake();
    chk("both_valid_clr", VEC_W'(bus.act_valid), '0);

    // Reset with one frame pending and another half written.
    beats(16'd0, 2'b01, 16'd0, 2'b01, 25);
    close_frame();
    beats(16'd640, 2'b01, 16'd640, 2'b01, 12);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mrst_valid", VEC_W'(bus.act_valid), '0);
    chk("mrst_busy",  VEC_W'(bus.busy),      '0);
    chk("mrst_ovf",   VEC_W'(bus.err_ovf),   '0);
    chk("mrst_short", VEC_W'(bus.err_short), '0);
    chk("mrst_vec",   bus.act_vec,           '0);
    beats(16'd8127, 2'b01, 16'd640, 2'b10, 25);
    close_frame();
    chk("mrst_new_valid", VEC_W'(bus.act_valid), VEC_W'(1));
    chk("mrst_new_vec", bus.act_vec, mkvec(8'h01, 8'h8B, 8'h01, 8'h8B));
    chk("mrst_new_busy", VEC_W'(bus.busy), '0);
    handshake();
    chk("mrst_new_clr", VEC_W'(bus.act_valid), '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
